shader_arbiter: RTL and testbench
=================================

SHADER_ARBITER -- requirements
Module: shader_arbiter

Interface
REQ-001 Parameter: LAT, default 1, shader_core issue-to-valid_out latency in cycles (legal 1..8).
REQ-002 Parameter: STARVE_MAX, default 8, consecutive aux-loss cycles before forced aux grant (legal 1..255).
REQ-003 Port: clk_25mhz  in  1  sole clock, all state on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: scan_req  in  1  scanout quad request, level, cannot be back-pressured.
REQ-006 Port: scan_x  in  9  scanout pixel x.
REQ-007 Port: scan_y  in  9  scanout pixel y.
REQ-008 Port: aux_valid  in  1  auxiliary (blit/compute) quad request.
REQ-009 Port: aux_ready  out  1  aux request accepted this cycle.
REQ-010 Port: aux_x  in  9  aux pixel x.
REQ-011 Port: aux_y  in  9  aux pixel y.
REQ-012 Port: sh_x_base  out  9  registered quad x issued to shader_core.
REQ-013 Port: sh_y  out  9  registered quad y issued to shader_core.
REQ-014 Port: sh_valid  out  1  registered issue strobe to shader_core valid_in.
REQ-015 Port: sh_done  in  1  shader_core valid_out.
REQ-016 Port: rsp_scan  out  1  current shader result belongs to scanout.
REQ-017 Port: rsp_aux  out  1  current shader result belongs to aux.
REQ-018 Port: scan_miss  out  1  one-cycle pulse: scan_req present but not issued.
REQ-019 Port: err  out  1  sticky: sh_done disagrees with tag pipeline.

Function
REQ-020 Arbitration is combinational on inputs; issue outputs sh_x_base/sh_y/sh_valid are registered, one quad per cycle max.
REQ-021 Default priority: scan_req wins; aux granted (aux_ready=1) only when scan_req=0 and aux_valid=1.
REQ-022 Issued x: sh_x_base = selected x with bits[1:0] forced to 0; y passed unmodified.
REQ-023 No grant in a cycle: sh_valid=0 next cycle, sh_x_base/sh_y hold last value.
REQ-024 Tag pipeline: LAT-deep shift register of {valid, owner}, loaded from the sh_valid/owner being issued, advancing every cycle.
REQ-025 rsp_scan = sh_done & tag_valid & (owner==scan) at depth LAT; rsp_aux likewise for aux; never both high.
REQ-026 err sets when sh_done != tag_valid at depth LAT; clears only on reset.
REQ-027 Starve counter: increments (saturating at 255) each cycle aux_valid=1 and aux_ready=0; clears on aux grant or aux_valid=0.
REQ-028 scan_miss pulses in any cycle scan_req=1 and scanout not granted; always 0 when STARVE_GUARD disabled.
REQ-029 Simultaneous scan_req and aux_valid with counter < STARVE_MAX: scan granted, aux counter increments.

Reset
REQ-030 rst_n low asynchronously clears: sh_valid, sh_x_base, sh_y, tag pipeline, starve counter, err, scan_miss, rsp_scan, rsp_aux, aux_ready all to 0.
REQ-031 Reset mid-flight discards all in-flight tags; sh_done arriving within LAT cycles after release sets no rsp and sets err.
REQ-032 First possible issue: first rising edge after rst_n deasserts.

Configuration
REQ-033 Macro SHADER_ARB_STARVE_GUARD_EN defined: when counter == STARVE_MAX and aux_valid=1, aux is granted for exactly one cycle over scan_req, scan_miss pulses, counter clears.
REQ-034 Macro undefined: strict scan priority, counter logic and STARVE_MAX unused, scan_miss tied 0, aux may starve indefinitely.

Verification
REQ-035 Scan only: scan_req=1, scan_x=0x107, scan_y=5 -> next cycle sh_valid=1, sh_x_base=0x104, sh_y=5; LAT cycles later sh_done=1 -> rsp_scan=1, rsp_aux=0.
REQ-036 Aux only: aux_valid=1, aux_x=0x013 -> aux_ready=1 same cycle, sh_x_base=0x010 next cycle, rsp_aux=1 when sh_done returns.
REQ-037 Contention, guard on, STARVE_MAX=8: scan_req and aux_valid held high -> aux_ready=1 and scan_miss=1 on 9th cycle, then scan wins 8 cycles, repeating; guard off -> aux_ready never 1.
REQ-038 Protocol error: sh_done=1 with no issue LAT cycles earlier -> err=1, stays 1 until rst_n low.
REQ-039 Reset mid-flight: issue 3 scan quads, assert rst_n low before results -> all outputs 0 immediately, no rsp_scan after release.

Source files
------------

// File: rtl/shader_arbiter.sv
// Shader issue arbiter: picks one quad per cycle from scanout or aux, registers the
// issue to shader_core and tags each issue so returning results can be routed.
// Optional macro SHADER_ARB_STARVE_GUARD_EN: lets a starved aux request win over scanout
// for one cycle once it has lost STARVE_MAX consecutive cycles.
module shader_arbiter #(
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk_25mhz,
  input  logic       rst_n,
  input  logic       scan_req,
  input  logic [8:0] scan_x,
  input  logic [8:0] scan_y,
  input  logic       aux_valid,
  output logic       aux_ready,
  input  logic [8:0] aux_x,
  input  logic [8:0] aux_y,
  output logic [8:0] sh_x_base,
  output logic [8:0] sh_y,
  output logic       sh_valid,
  input  logic       sh_done,
  output logic       rsp_scan,
  output logic       rsp_aux,
  output logic       scan_miss,
  output logic       err
);

  logic [7:0]     starve_q, starve_d;
  logic           starved;
  logic           force_aux;
  logic           scan_gnt, aux_gnt;
  logic           sh_valid_q, owner_q;   // owner: 1 = aux, 0 = scanout
  logic [8:0]     sh_x_q, sh_y_q;
  logic [LAT-1:0] tag_v_q, tag_o_q;
  logic           err_q, err_d;

  assign starved = (starve_q == 8'(STARVE_MAX));

`ifdef SHADER_ARB_STARVE_GUARD_EN
  assign force_aux = aux_valid & starved;
  // Scanout loses only in the forced-aux cycle.
  assign scan_miss = scan_req & force_aux & rst_n;
`else
  logic unused_starved;
  assign unused_starved = starved;
  assign force_aux      = 1'b0;
  assign scan_miss      = 1'b0;
`endif

  // Grant selection: scanout first unless the starvation guard forces aux.
  always_comb begin
    scan_gnt = scan_req & ~force_aux;
    aux_gnt  = aux_valid & (~scan_req | force_aux);
  end

  // Combinational handshake is held low while reset is asserted.
  assign aux_ready = aux_gnt & rst_n;

  // Starve counter next state: counts consecutive aux losses, saturating.
  always_comb begin
    starve_d = starve_q;
    if (!aux_valid || aux_gnt) begin
      starve_d = 8'd0;
    end else if (starve_q != 8'hff) begin
      starve_d = starve_q + 8'd1;
    end
  end

  // Protocol check: a result must line up with a valid tag at depth LAT.
  always_comb begin
    err_d = err_q | (sh_done != tag_v_q[LAT-1]);
  end

  // Issue registers, tag pipeline, counter and sticky error.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      sh_valid_q <= 1'b0;
      owner_q    <= 1'b0;
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      tag_v_q    <= '0;
      tag_o_q    <= '0;
      starve_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      sh_valid_q <= scan_gnt | aux_gnt;
      if (scan_gnt) begin
        owner_q <= 1'b0;
        sh_x_q  <= {scan_x[8:2], 2'b00};
        sh_y_q  <= scan_y;
      end else if (aux_gnt) begin
        owner_q <= 1'b1;
        sh_x_q  <= {aux_x[8:2], 2'b00};
        sh_y_q  <= aux_y;
      end
      // Stage 0 captures what shader_core sees this cycle; stage LAT-1 meets sh_done.
      tag_v_q[0] <= sh_valid_q;
      tag_o_q[0] <= owner_q;
      for (int i = 1; i < LAT; i++) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_o_q[i] <= tag_o_q[i-1];
      end
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign sh_valid  = sh_valid_q;
  assign sh_x_base = sh_x_q;
  assign sh_y      = sh_y_q;
  assign err       = err_q;
  assign rsp_scan  = sh_done & tag_v_q[LAT-1] & ~tag_o_q[LAT-1];
  assign rsp_aux   = sh_done & tag_v_q[LAT-1] & tag_o_q[LAT-1];

endmodule

// File: tb/tb_shader_arbiter.sv
// Bench for shader_arbiter: vector table, hand sequences and random traffic against
// a queue-based reference model of issue ownership and result routing.
module tb_shader_arbiter;

  localparam int unsigned LAT  = 3;
  localparam int unsigned SMAX = 4;
`ifdef SHADER_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic       clk_25mhz = 1'b0;
  logic       rst_n     = 1'b0;
  logic       scan_req  = 1'b0;
  logic [8:0] scan_x    = '0;
  logic [8:0] scan_y    = '0;
  logic       aux_valid = 1'b0;
  logic [8:0] aux_x     = '0;
  logic [8:0] aux_y     = '0;
  logic       sh_done   = 1'b0;
  logic       aux_ready, sh_valid, rsp_scan, rsp_aux, scan_miss, err;
  logic [8:0] sh_x_base, sh_y;

  shader_arbiter #(.LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk_25mhz (clk_25mhz),
    .rst_n     (rst_n),
    .scan_req  (scan_req),
    .scan_x    (scan_x),
    .scan_y    (scan_y),
    .aux_valid (aux_valid),
    .aux_ready (aux_ready),
    .aux_x     (aux_x),
    .aux_y     (aux_y),
    .sh_x_base (sh_x_base),
    .sh_y      (sh_y),
    .sh_valid  (sh_valid),
    .sh_done   (sh_done),
    .rsp_scan  (rsp_scan),
    .rsp_aux   (rsp_aux),
    .scan_miss (scan_miss),
    .err       (err)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  int checks = 0;
  int errors = 0;

  // Reference model: issue kind per cycle (0 none, 1 scan, 2 aux), results due LAT later.
  int         hist[$];
  int         m_kind;
  int         m_starve;
  bit         m_err;
  bit [8:0]   m_x, m_y;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < int'(LAT); i++) hist.push_back(0);
    m_kind = 0; m_starve = 0; m_err = 0; m_x = '0; m_y = '0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, then registered ones.
  task automatic step(input bit sr, input bit [8:0] sx, input bit [8:0] sy,
                      input bit av, input bit [8:0] ax, input bit [8:0] ay,
                      input bit auto_done, input bit done_val, output bit ar_seen);
    bit force_a, a_gnt, s_gnt, done;
    int head;
    @(negedge clk_25mhz);
    head = hist[0];
    done = auto_done ? (head != 0) : done_val;
    scan_req = sr; scan_x = sx; scan_y = sy;
    aux_valid = av; aux_x = ax; aux_y = ay; sh_done = done;
    force_a = Guard && av && (m_starve == int'(SMAX));
    a_gnt   = av && (!sr || force_a);
    s_gnt   = sr && !force_a;
    #1;
    ar_seen = aux_ready;
    chk("aux_ready", aux_ready, a_gnt);
    chk("scan_miss", scan_miss, sr && !s_gnt);
    chk("rsp_scan", rsp_scan, done && head == 1);
    chk("rsp_aux", rsp_aux, done && head == 2);
    @(posedge clk_25mhz);
    if (done != (head != 0)) m_err = 1;
    void'(hist.pop_front());
    hist.push_back(m_kind);
    m_kind = s_gnt ? 1 : (a_gnt ? 2 : 0);
    if (s_gnt) begin m_x = sx & 9'h1fc; m_y = sy; end
    else if (a_gnt) begin m_x = ax & 9'h1fc; m_y = ay; end
    if (!av || a_gnt) m_starve = 0;
    else if (m_starve < 255) m_starve++;
    #1;
    chk("sh_valid", sh_valid, m_kind != 0);
    chk("sh_x_base", sh_x_base, m_x);
    chk("sh_y", sh_y, m_y);
    chk("err", err, m_err);
  endtask

  task automatic idle(input int n);
    bit s;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 1, 0, s);
  endtask

  // Asynchronous reset mid-cycle with requests pending; all outputs must drop at once.
  task automatic do_reset();
    @(posedge clk_25mhz);
    #4;
    scan_req = 1; aux_valid = 1; sh_done = 1;
    rst_n = 0;
    #1;
    chk("rst_sh_valid", sh_valid, 0);
    chk("rst_sh_x_base", sh_x_base, 0);
    chk("rst_sh_y", sh_y, 0);
    chk("rst_aux_ready", aux_ready, 0);
    chk("rst_scan_miss", scan_miss, 0);
    chk("rst_rsp_scan", rsp_scan, 0);
    chk("rst_rsp_aux", rsp_aux, 0);
    chk("rst_err", err, 0);
    scan_req = 0; aux_valid = 0; sh_done = 0;
    model_reset();
    @(negedge clk_25mhz);
    rst_n = 1;
  endtask

  typedef struct {
    bit       sr;
    bit [8:0] sx, sy;
    bit       av;
    bit [8:0] ax, ay;
    bit       e_ar, e_v;
    bit [8:0] e_x, e_y;
  } vec_t;

  initial begin
    vec_t vt[6];
    bit   s;
    int   ar_cnt;

    vt[0] = '{1, 9'h107, 9'd5,   0, 9'h000, 9'd0, 0, 1, 9'h104, 9'd5};
    vt[1] = '{0, 9'h000, 9'd0,   1, 9'h013, 9'd7, 1, 1, 9'h010, 9'd7};
    vt[2] = '{0, 9'h000, 9'd0,   0, 9'h000, 9'd0, 0, 0, 9'h010, 9'd7};
    vt[3] = '{1, 9'h0ff, 9'h1ff, 1, 9'h055, 9'd2, 0, 1, 9'h0fc, 9'h1ff};
    vt[4] = '{0, 9'h000, 9'd0,   1, 9'h1fe, 9'd3, 1, 1, 9'h1fc, 9'd3};
    vt[5] = '{1, 9'h003, 9'd0,   0, 9'h000, 9'd0, 0, 1, 9'h000, 9'd0};

    model_reset();
    do_reset();

    // Vector table; results returned on time so routing is checked as they come back.
    for (int i = 0; i < 6; i++) begin
      step(vt[i].sr, vt[i].sx, vt[i].sy, vt[i].av, vt[i].ax, vt[i].ay, 1, 0, s);
      chk("vec_aux_ready", s, vt[i].e_ar);
      chk("vec_sh_valid", sh_valid, vt[i].e_v);
      chk("vec_sh_x_base", sh_x_base, vt[i].e_x);
      chk("vec_sh_y", sh_y, vt[i].e_y);
    end
    idle(LAT + 1);

    // Sustained contention: forced aux every SMAX+1 cycles only with the guard built in.
    ar_cnt = 0;
    for (int i = 0; i < 2 * int'(SMAX + 1); i++) begin
      step(1, 9'h020, 9'd1, 1, 9'h031, 9'd2, 1, 0, s);
      ar_cnt += int'(s);
    end
    chk("contention_aux_grants", ar_cnt, Guard ? 2 : 0);
    idle(LAT + 1);

    // Random traffic with correctly timed results.
    for (int i = 0; i < 300; i++) begin
      step(bit'($urandom_range(0, 1)), 9'($urandom), 9'($urandom),
           bit'($urandom_range(0, 3) != 0), 9'($urandom), 9'($urandom), 1, 0, s);
    end
    idle(LAT + 1);

    // Result with no matching issue: sticky error until reset.
    step(0, 0, 0, 0, 0, 0, 0, 1, s);
    chk("err_set", err, 1);
    idle(4);
    chk("err_sticky", err, 1);
    do_reset();
    idle(1);

    // Reset with three scan quads in flight: their results must never be routed.
    for (int i = 0; i < 3; i++) step(1, 9'(i * 4), 9'(i), 0, 0, 0, 1, 0, s);
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 1, s);
    chk("post_reset_done_err", err, 1);
    idle(LAT);
    do_reset();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
